// File: rtl/ieee754_pkg.sv
// Shared types and constants for the front-panel IEEE754 conversion path.
package ieee754_pkg;

  localparam int RESULT_W = 16;

  localparam logic [7:0] MASK_NONE   = 8'h00;
  localparam logic [7:0] MASK_RESULT = 8'h0F;

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_FAULT = 2'd3
  } seq_state_t;

  // Lowest n digits enabled; saturates at all eight digits.
  function automatic logic [7:0] digit_mask(input int n);
    logic [7:0] m;
    m = MASK_NONE;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/conv_watchdog.sv
// Clearable, enabled cycle counter; expired_o is high once TIMEOUT-1 cycles have been counted.
// Counter saturates at TIMEOUT-1; no backpressure.
module conv_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/conversion_sequencer.sv
// Builds the operand from switch nibbles, issues/supervises one conversion and drives the 7-seg display word.
// All outputs registered (1-cycle latency from sampled input); pulse inputs, no backpressure.
module conversion_sequencer
  import ieee754_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  enter,
  input  logic                  confirm,
  input  logic [3:0]            switches,
  output logic                  conv_req,
  output logic                  conv_abort,
  output logic [4*DIGITS-1:0]   conv_data,
  input  logic                  conv_done,
  input  logic [RESULT_W-1:0]   conv_result,
  input  logic                  conv_error,
  output logic [31:0]           show,
  output logic [7:0]            mask,
  output logic                  error
);

  localparam int              OPW        = 4 * DIGITS;
  localparam int              CNTW       = $clog2(DIGITS + 1);
  localparam logic [CNTW-1:0] COUNT_FULL = CNTW'(DIGITS);

  seq_state_t          state_q, state_d;
  logic [OPW-1:0]      operand_q, operand_d;
  logic [CNTW-1:0]     count_q, count_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic                req_q, req_d;
  logic                abort_q;
  logic [31:0]         show_q, show_d;
  logic [7:0]          mask_q, mask_d;
  logic                error_q, error_d;
  logic                wd_clr, wd_en, wd_expired;

  conv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (wd_clr),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  assign wd_en = (state_q == ST_BUSY);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    count_d   = count_q;
    result_d  = result_q;
    req_d     = 1'b0;
    wd_clr    = 1'b0;

    if (clr) begin
      state_d   = ST_ENTRY;
      operand_d = '0;
      count_d   = '0;
      result_d  = '0;
      wd_clr    = 1'b1;
    end else begin
      unique case (state_q)
        ST_ENTRY: begin
          // confirm takes priority; a nibble entered in the same cycle is dropped
          if (confirm) begin
            if (count_q != '0) begin
              req_d   = 1'b1;
              wd_clr  = 1'b1;
              state_d = ST_BUSY;
            end
          end else if (enter && (count_q != COUNT_FULL)) begin
            operand_d = OPW'({operand_q, switches});
            count_d   = count_q + CNTW'(1);
          end
        end
        ST_BUSY: begin
          if (conv_error) begin
            state_d = ST_FAULT;
          end else if (conv_done) begin
            result_d = conv_result;
            state_d  = ST_SHOW;
          end else if (wd_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_SHOW:  state_d = ST_SHOW;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_ENTRY;
      endcase
    end
  end

  // Display is derived from next-state values so it lands with the state change.
  always_comb begin
    show_d  = '0;
    mask_d  = MASK_NONE;
    error_d = 1'b0;
    unique case (state_d)
      ST_ENTRY, ST_BUSY: begin
        show_d = 32'(operand_d);
        mask_d = digit_mask(int'(count_d));
      end
      ST_SHOW: begin
        show_d = 32'(result_d);
        mask_d = MASK_RESULT;
      end
      ST_FAULT: begin
        error_d = 1'b1;
      end
      default: begin
        show_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTRY;
      operand_q <= '0;
      count_q   <= '0;
      result_q  <= '0;
      req_q     <= 1'b0;
      abort_q   <= 1'b0;
      show_q    <= '0;
      mask_q    <= MASK_NONE;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      count_q   <= count_d;
      result_q  <= result_d;
      req_q     <= req_d;
      abort_q   <= clr;
      show_q    <= show_d;
      mask_q    <= mask_d;
      error_q   <= error_d;
    end
  end

  // Operand only moves in ENTRY, so it doubles as the frozen converter operand.
  assign conv_data  = operand_q;
  assign conv_req   = req_q;
  assign conv_abort = abort_q;
  assign show       = show_q;
  assign mask       = mask_q;
  assign error      = error_q;

endmodule

// File: doc/conversion_sequencer.md
# conversion_sequencer

Control stage between the debounced front-panel inputs and the 16-bit IEEE754 conversion engine. It builds the operand one nibble at a time from the switches, issues a single-cycle start request to the converter, and supervises the request with a watchdog. It then drives the display word, digit mask and error flag consumed by the 7-segment controller. All glue registers that currently live at the top level move into this block.

## Interface
Parameters:
- `DIGITS`, 4: operand length in hex digits; operand width is 4*DIGITS.
- `TIMEOUT`, 1024: maximum cycles allowed in BUSY before FAULT; must be ≥ 2.

Ports:
- `clk` in 1: system clock, 100 MHz domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: debounced soft-clear pulse, one cycle, synchronous.
- `enter` in 1: debounced pulse, one cycle; shifts `switches` into the operand.
- `confirm` in 1: debounced pulse, one cycle; starts a conversion.
- `switches` in 4: nibble to enter.
- `conv_req` out 1: one-cycle start pulse to the converter.
- `conv_abort` out 1: one-cycle pulse to reset the converter.
- `conv_data` out 4*DIGITS: operand, stable while BUSY.
- `conv_done` in 1: converter result-valid pulse.
- `conv_result` in 16: converter result, valid with `conv_done`.
- `conv_error` in 1: converter error pulse.
- `show` out 32: display word; digit i is `show[4i+3:4i]`.
- `mask` out 8: bit i enables digit i.
- `error` out 1: fault indicator for the display.

## Operation
- States: ENTRY, BUSY, SHOW, FAULT. Reset state is ENTRY.
- Global rule: `clr` outranks every other input in every state. On `clr`:
  - state becomes ENTRY; operand, digit count and result become 0;
  - `conv_abort` pulses for one cycle.
- ENTRY:
  - `enter`: operand <= {operand[4*DIGITS-5:0], switches}. Count increments and saturates at DIGITS.
  - Full rule: once count == DIGITS, further `enter` is ignored and the operand is unchanged.
  - `confirm` with count ≥ 1: pulse `conv_req`, clear the watchdog, go to BUSY.
  - `confirm` with count == 0: ignored.
  - `enter` and `confirm` in the same cycle: `confirm` wins and the nibble is dropped.
  - Display: `show` = zero-extended operand; `mask` = (1<<count)-1.
- BUSY:
  - `enter` and `confirm` are ignored. The watchdog increments each cycle.
  - `conv_error` (with or without `conv_done`) → FAULT.
  - `conv_done` alone → latch `conv_result`, go to SHOW.
  - Watchdog reaching TIMEOUT-1 without `conv_done` → FAULT. If `conv_done` arrives on the timeout cycle, `conv_done` wins.
  - Display: unchanged operand view.
- SHOW:
  - Display: `show` = {16'h0, result}; `mask` = 8'h0F.
  - Only `clr` exits. Stray `conv_done` is ignored and does not overwrite the result.
- FAULT:
  - Outputs: `error` = 1, `show` = 0, `mask` = 0.
  - Only `clr` exits.
- `conv_done` and `conv_error` are ignored outside BUSY.

## Timing
- All outputs are registered.
- Reset values: `conv_req` 0, `conv_abort` 0, `conv_data` 0, `show` 0, `mask` 0, `error` 0.
- `conv_req` is high in the cycle after `confirm` is sampled. It is exactly one cycle wide and never re-issued during BUSY.
- `conv_data` is updated only in ENTRY, so it is frozen from the `conv_req` cycle until leaving BUSY.
- Latencies:
  - `show`/`mask` reflect an `enter`, `conv_done` or `clr` one cycle after the input is sampled.
  - `error` rises one cycle after the FAULT transition condition.
- Timeout: FAULT is entered TIMEOUT cycles after the `conv_req` cycle when no done or error arrives.
- Asynchronous `rst_n` mid-conversion: immediate return to ENTRY with reset values. `conv_abort` is not pulsed; the converter shares `rst_n`.

## Structure
- Shared package `ieee754_pkg`:
  - state enum `seq_state_t`;
  - `RESULT_W` = 16;
  - mask constants `MASK_NONE` = 8'h00 and `MASK_RESULT` = 8'h0F.
- One sub-module: `conv_watchdog`, a clearable/enabled counter with TIMEOUT parameter and an `expired` output.
- Everything else is flat in `conversion_sequencer`.

## Test plan
- Entry:
  - Stimulus: enter 0xA, 0x1, 0xF, 0x3, then one extra enter 0x7.
  - Expect: `show` = 0x0000A1F3 and `mask` = 0x0F after the 4th enter, both unchanged after the 5th.
- Conversion:
  - Stimulus: confirm with count 2, then `conv_done` with `conv_result` = 0x3C00 three cycles later.
  - Expect: one `conv_req` pulse, then `show` = 0x00003C00 and `mask` = 0x0F.
- Error:
  - Stimulus: `conv_done` and `conv_error` in the same BUSY cycle.
  - Expect: FAULT; `error` = 1, `show` = 0, `mask` = 0.
- Timeout:
  - Stimulus: TIMEOUT = 8, no response after confirm.
  - Expect: `error` = 1 eight cycles after `conv_req`; a late `conv_done` is ignored.
- Clear in BUSY:
  - Stimulus: `clr` during BUSY, then `conv_done` arrives.
  - Expect: `conv_abort` pulses once; state is ENTRY with `show` = 0 and `mask` = 0; the later `conv_done` is ignored.
- Entry edge cases:
  - Stimulus: confirm with count 0; then `enter` and `confirm` together.
  - Expect: first confirm gives no `conv_req`. With count ≥ 1, the simultaneous pair gives `conv_req` and the nibble is dropped.
